// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encodings, the default
// channel-tag base byte and the channel-index width helper.
package uart_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TAG  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hF0;

  // Channel index width; never zero so single-bit indices stay legal.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used per arbiter channel. Pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter. Read data is
// the head entry, valid whenever empty is low.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer advance; a push into a full FIFO or a pop from an empty one is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// N-channel buffered round-robin arbiter feeding a single UART transmitter.
// Each channel has its own sync_fifo; the FSM pops one byte per grant and holds
// it on tx_data until the transmitter accepts it.
// Optional feature macro: UART_ARB_CHTAG_EN -- when defined, a tag byte
// (TAG_BASE | channel) precedes the data byte whenever the channel changes and
// for the first byte after reset.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_CH     = 2,
  parameter int         DATA_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] TAG_BASE   = TAG_BASE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_CH)-1:0]  cur_ch
);

  localparam int CH_W = ch_w(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
    $error("uart_tx_arbiter: NUM_CH must be 2..16 and FIFO_DEPTH a power of two >= 2");
  end

  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_pop;
  logic [DATA_W-1:0] fifo_rdata [NUM_CH];
  logic [1:0]        state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   win;
  logic              found;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid[c]),
      .wdata (in_data[c*DATA_W +: DATA_W]),
      .pop   (fifo_pop[c]),
      .rdata (fifo_rdata[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
    assign fifo_pop[c] = (state == ST_IDLE) && found && (win == CH_W'(c));
  end

  // Space is judged from registered occupancy only, so a same-cycle pop never frees a slot.
  assign in_ready = ~fifo_full;

  // Round-robin search: first non-empty channel at or above rr_ptr, else the lowest one below it.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && !fifo_empty[i] && CH_W'(i) >= rr_ptr) begin
        found = 1'b1;
        win   = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && !fifo_empty[i]) begin
        found = 1'b1;
        win   = CH_W'(i);
      end
    end
  end

`ifdef UART_ARB_CHTAG_EN
  if (DATA_W != 8 || NUM_CH > 16) begin : g_tag_chk
    $error("uart_tx_arbiter: channel tags need DATA_W == 8 and NUM_CH <= 16");
  end

  logic              last_vld;
  logic [CH_W-1:0]   last_ch;
  logic [DATA_W-1:0] data_hold;

  // Grant FSM with tag insertion: IDLE pops a winner, TAG sends the channel tag, DATA sends the byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      cur_ch   <= '0;
      rr_ptr   <= '0;
      last_vld <= 1'b0;
      last_ch  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            cur_ch   <= win;
            rr_ptr   <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
            tx_valid <= 1'b1;
            if (!last_vld || win != last_ch) begin
              tx_data   <= TAG_BASE | DATA_W'(win);
              data_hold <= fifo_rdata[win];
              state     <= ST_TAG;
            end else begin
              tx_data <= fifo_rdata[win];
              state   <= ST_DATA;
            end
          end
        end
        ST_TAG: begin
          if (tx_ready) begin
            tx_data <= data_hold;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            last_ch  <= cur_ch;
            last_vld <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end
`else
  // Grant FSM: IDLE pops a winner into tx_data, DATA holds it until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      cur_ch   <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            cur_ch   <= win;
            rr_ptr   <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
            tx_data  <= fifo_rdata[win];
            tx_valid <= 1'b1;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (2 channels, depth 4). Stimulus pushes the
// expected output bytes into a queue; a monitor pops and compares on each accepted byte.
module tb_uart_tx_arbiter;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     cur_ch;

  uart_tx_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .cur_ch   (cur_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ch;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
`ifdef UART_ARB_CHTAG_EN
  int   model_last = -1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_byte(input int ch, input logic [7:0] d);
    exp_t e;
`ifdef UART_ARB_CHTAG_EN
    if (model_last != ch) begin
      e.ch   = ch[0];
      e.data = 8'hF0 | 8'(ch);
      exp_q.push_back(e);
    end
    model_last = ch;
`endif
    e.ch   = ch[0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_reset();
    exp_q.delete();
`ifdef UART_ARB_CHTAG_EN
    model_last = -1;
`endif
  endtask

  // Called aligned to a negedge; the byte is written at the following posedge.
  task automatic push(input int ch, input logic [7:0] d);
    in_valid = '0;
    in_valid[ch] = 1'b1;
    in_data[ch*DATA_W +: DATA_W] = d;
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_idle"}, tx_valid, 0);
  endtask

  // Monitor: compare each accepted byte and check tx_data holds while stalled.
  initial begin : monitor
    exp_t       e;
    logic       prev_vld;
    logic       prev_acc;
    logic [7:0] prev_data;
    prev_vld  = 1'b0;
    prev_acc  = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_vld = 1'b0;
      end else begin
        if (prev_vld && !prev_acc && tx_valid) chk("tx_data_stable", tx_data, prev_data);
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h on ch %0d, expected no output at %0t", tx_data, cur_ch, $time);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e.data);
            chk("cur_ch", cur_ch, e.ch);
          end
        end
        prev_vld  = tx_valid;
        prev_acc  = tx_valid && tx_ready;
        prev_data = tx_data;
      end
    end
  end

  initial begin : stimulus
    int n;
    rst_n    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    tx_ready = 1'b1;

    // Reset while ch0 tries to write: nothing may be stored or emitted.
    @(negedge clk);
    in_valid = 2'b01;
    in_data  = {8'h00, 8'h41};
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx_valid", tx_valid, 0);
    end
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cur_ch", cur_ch, 0);
    in_valid = '0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 2'b11);
    chk("rst_idle", tx_valid, 0);
    repeat (8) @(negedge clk);
    chk("rst_no_output", tx_valid, 0);

    // Single byte on ch1 with latency and width checks.
    exp_byte(1, 8'h55);
    push(1, 8'h55);
    chk("lat_t1", tx_valid, 0);
    @(negedge clk);
    chk("lat_t2", tx_valid, 1);
    chk("lat_t2_ch", cur_ch, 1);
`ifdef UART_ARB_CHTAG_EN
    chk("lat_t2_tag", tx_data, 8'hF1);
    @(negedge clk);
    chk("lat_t3_data", tx_data, 8'h55);
    chk("lat_t3_valid", tx_valid, 1);
`else
    chk("lat_t2_data", tx_data, 8'h55);
`endif
    @(negedge clk);
    chk("lat_one_wide", tx_valid, 0);
    wait_drain("single", 20);

    // Channel-change sequence: ch0 10, ch0 11, then ch1 20.
    exp_byte(0, 8'h10);
    exp_byte(0, 8'h11);
    push(0, 8'h10);
    push(0, 8'h11);
    wait_drain("seq_a", 30);
    exp_byte(1, 8'h20);
    push(1, 8'h20);
    wait_drain("seq_b", 30);

    // Round robin: both channels write three bytes in the same cycles.
    for (int k = 0; k < 3; k++) begin
      exp_byte(0, 8'hA0 + 8'(k));
      exp_byte(1, 8'hB0 + 8'(k));
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 2'b11;
      in_data  = {8'hB0 + 8'(k), 8'hA0 + 8'(k)};
      @(negedge clk);
    end
    in_valid = '0;
    wait_drain("rr", 200);

    // Backpressure: five bytes into ch0 with the transmitter stalled.
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) exp_byte(0, 8'hC0 + 8'(k));
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", in_ready[0], 1);
      in_valid = 2'b01;
      in_data  = {8'h00, 8'hC0 + 8'(k)};
      @(negedge clk);
    end
    in_valid = '0;
    chk("bp_full", in_ready[0], 0);
`ifdef UART_ARB_CHTAG_EN
    chk("bp_hold", tx_data, 8'hF0);
`else
    chk("bp_hold", tx_data, 8'hC0);
`endif
    repeat (15) @(negedge clk);
    chk("bp_still_valid", tx_valid, 1);
    chk("bp_still_full", in_ready[0], 0);
`ifdef UART_ARB_CHTAG_EN
    chk("bp_hold_late", tx_data, 8'hF0);
`else
    chk("bp_hold_late", tx_data, 8'hC0);
`endif
    tx_ready = 1'b1;
    wait_drain("bp", 100);

    // Reset while a byte is held with the transmitter stalled.
    tx_ready = 1'b0;
    exp_byte(0, 8'h77);
    push(0, 8'h77);
    n = 0;
    while (!tx_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_valid", tx_valid, 1);
    chk("mid_data", tx_data, 8'h77);
    rst_n = 1'b0;
    exp_reset();
    @(negedge clk);
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_data", tx_data, 0);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_no_reappear", tx_valid, 0);
    exp_byte(1, 8'h88);
    push(1, 8'h88);
    wait_drain("post_rst", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
